// File: rtl/pc_predict_unit.sv
// pc_predict_unit: fetch PC register with 2-bit counter branch prediction and resolve/redirect
// Ports:
//   clk, rst_n                clock (rising edge), asynchronous active-low reset
//   stall                     hold fetch_pc (overridden by redirect)
//   fetch_pc                  registered fetch address
//   if_is_br/if_ccc/if_imm    branch info for the instruction at fetch_pc
//   pred_taken                combinational prediction for fetch_pc
//   br_valid/br_pc/br_ccc/br_imm/br_pred/flags   resolving branch and {N,Z,V}
//   redirect/redirect_pc      mispredict flush and corrected next PC
//   br_taken                  actual outcome (0 when no branch resolves)
//   mispredicts               saturating mispredict count
module pc_predict_unit #(
    parameter int              ADDR_W    = 16,
    parameter int              IMM_W     = 9,
    parameter int              BHT_DEPTH = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int              CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    output logic [ADDR_W-1:0] fetch_pc,
    input  logic              if_is_br,
    input  logic [2:0]        if_ccc,
    input  logic [IMM_W-1:0]  if_imm,
    output logic              pred_taken,
    input  logic              br_valid,
    input  logic [ADDR_W-1:0] br_pc,
    input  logic [2:0]        br_ccc,
    input  logic [IMM_W-1:0]  br_imm,
    input  logic              br_pred,
    input  logic [2:0]        flags,
    output logic              redirect,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic              br_taken,
    output logic [CNT_W-1:0]  mispredicts
);
    localparam int IDX_W = $clog2(BHT_DEPTH);

    logic [1:0]        bht [BHT_DEPTH];
    logic [IDX_W-1:0]  f_idx, b_idx;
    logic [1:0]        ctr;
    logic [ADDR_W-1:0] next_pc;

    function automatic logic [ADDR_W-1:0] seq(input logic [ADDR_W-1:0] pc);
        return pc + ADDR_W'(2);
    endfunction

    // offset is in half-words, so the sign-extended immediate is doubled
    function automatic logic [ADDR_W-1:0] tgt(input logic [ADDR_W-1:0] pc, input logic [IMM_W-1:0] imm);
        return pc + ADDR_W'(2) + (ADDR_W'($signed(imm)) << 1);
    endfunction

    // flags = {N,Z,V}
    function automatic logic cond(input logic [2:0] c, input logic [2:0] f);
        logic n, z, v;
        n = f[2];
        z = f[1];
        v = f[0];
        case (c)
            3'b000:  return !z;
            3'b001:  return z;
            3'b010:  return !z && !n;
            3'b011:  return n;
            3'b100:  return z || (!z && !n);
            3'b101:  return n || z;
            3'b110:  return v;
            default: return 1'b1;
        endcase
    endfunction

    assign f_idx       = fetch_pc[IDX_W:1];
    assign b_idx       = br_pc[IDX_W:1];
    assign ctr         = bht[b_idx];
    assign pred_taken  = if_is_br && (if_ccc == 3'b111 || bht[f_idx][1]);
    assign br_taken    = br_valid && cond(br_ccc, flags);
    assign redirect    = br_valid && (br_taken != br_pred);
    assign redirect_pc = br_taken ? tgt(br_pc, br_imm) : seq(br_pc);

    always_comb begin
        next_pc = redirect ? redirect_pc : stall ? fetch_pc : pred_taken ? tgt(fetch_pc, if_imm) : seq(fetch_pc);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            mispredicts <= '0;
        end else begin
            fetch_pc <= next_pc;
            if (redirect && mispredicts != '1)
                mispredicts <= mispredicts + 1'b1;
        end
    end

    // unconditional branches carry no information and never train the table
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_DEPTH; i++)
                bht[i] <= 2'b01;
        end else if (br_valid && br_ccc != 3'b111) begin
            bht[b_idx] <= br_taken ? (ctr == 2'b11 ? ctr : ctr + 2'd1)
                                   : (ctr == 2'b00 ? ctr : ctr - 2'd1);
        end
    end
endmodule
